// File: rtl/mp_tcam_engine.sv
// Multi-port ternary CAM: one write/invalidate port, NPORT 3-stage search pipelines, chunked flush FSM.
// Optional CAM_MATCH_COUNT_EN adds the per-port rCount output (number of matching valid entries).
module mp_tcam_engine #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 36,
  parameter int NPORT = 2,
  parameter int CHUNK = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wEn,
  input  logic [$clog2(DEPTH)-1:0]         wAddr,
  input  logic [WIDTH-1:0]                 wPatt,
  input  logic [WIDTH-1:0]                 wMask,
  input  logic                             wValid,
  output logic                             wDrop,
  input  logic                             flush,
  output logic                             flushBusy,
  input  logic [NPORT-1:0]                 sValid,
  output logic                             sReady,
  input  logic [NPORT*WIDTH-1:0]           sPatt,
  output logic [NPORT-1:0]                 rValid,
  output logic [NPORT-1:0]                 rMatch,
  output logic [NPORT-1:0]                 rMulti,
`ifdef CAM_MATCH_COUNT_EN
  output logic [NPORT*$clog2(DEPTH+1)-1:0] rCount,
`endif
  output logic [NPORT*$clog2(DEPTH)-1:0]   rAddr
);

  localparam int AW     = $clog2(DEPTH);
  localparam int NCHUNK = DEPTH / CHUNK;
  localparam int FW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state;
  logic [FW-1:0]    cnt;
  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] patt [DEPTH];
  logic [WIDTH-1:0] mask [DEPTH];

  logic [WIDTH-1:0] key_q   [NPORT];
  logic [DEPTH-1:0] match_d [NPORT];
  logic [DEPTH-1:0] match_q [NPORT];
  logic [NPORT-1:0] v1, v2;

  function automatic logic [AW-1:0] lowest(input logic [DEPTH-1:0] m);
    lowest = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (m[i]) lowest = AW'(i);
  endfunction

`ifdef CAM_MATCH_COUNT_EN
  localparam int CW = $clog2(DEPTH + 1);

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] m);
    popcount = '0;
    for (int i = 0; i < DEPTH; i++)
      popcount = popcount + CW'(m[i]);
  endfunction
`endif

  // Control FSM: flushBusy/sReady are registered copies of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      valid     <= '0;
      flushBusy <= 1'b0;
      sReady    <= 1'b0;
      wDrop     <= 1'b0;
    end else begin
      wDrop <= wEn && (state == FLUSH);
      case (state)
        IDLE: begin
          if (wEn) valid[wAddr] <= wValid;
          if (flush) begin
            state     <= FLUSH;
            cnt       <= '0;
            flushBusy <= 1'b1;
            sReady    <= 1'b0;
          end else begin
            sReady <= 1'b1;
          end
        end
        FLUSH: begin
          valid[cnt*CHUNK +: CHUNK] <= '0;
          cnt <= cnt + FW'(1);
          if (cnt == FW'(NCHUNK - 1)) begin
            state     <= IDLE;
            flushBusy <= 1'b0;
            sReady    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pattern storage needs no reset: a cleared valid bit hides stale contents.
  always_ff @(posedge clk) begin
    if (wEn && (state == IDLE) && wValid) begin
      patt[wAddr] <= wPatt;
      mask[wAddr] <= wMask;
    end
  end

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      match_d[p] = '0;
      for (int i = 0; i < DEPTH; i++)
        match_d[p][i] = valid[i] && (((patt[i] ^ key_q[p]) & ~mask[i]) == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= '0;
      v2     <= '0;
      rValid <= '0;
      rMatch <= '0;
      rMulti <= '0;
      rAddr  <= '0;
`ifdef CAM_MATCH_COUNT_EN
      rCount <= '0;
`endif
      for (int p = 0; p < NPORT; p++) begin
        key_q[p]   <= '0;
        match_q[p] <= '0;
      end
    end else begin
      v2     <= v1;
      rValid <= v2;
      for (int p = 0; p < NPORT; p++) begin
        v1[p] <= sValid[p] && sReady;
        if (sValid[p] && sReady) key_q[p] <= sPatt[p*WIDTH +: WIDTH];
        match_q[p] <= match_d[p];
        rMatch[p]  <= v2[p] && (match_q[p] != '0);
        rMulti[p]  <= v2[p] && ((match_q[p] & (match_q[p] - DEPTH'(1))) != '0);
        rAddr[p*AW +: AW] <= v2[p] ? lowest(match_q[p]) : '0;
`ifdef CAM_MATCH_COUNT_EN
        rCount[p*CW +: CW] <= v2[p] ? popcount(match_q[p]) : '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mp_tcam_engine.sv
// Directed bench for mp_tcam_engine (DEPTH=64, WIDTH=36, NPORT=2, CHUNK=8) with hand-computed expectations.
module tb_mp_tcam_engine;
  localparam int DEPTH = 64;
  localparam int WIDTH = 36;
  localparam int NPORT = 2;
  localparam int CHUNK = 8;
  localparam int AW    = 6;
  localparam int CW    = 7;

  logic                   clk;
  logic                   rst_n;
  logic                   wEn;
  logic [AW-1:0]          wAddr;
  logic [WIDTH-1:0]       wPatt;
  logic [WIDTH-1:0]       wMask;
  logic                   wValid;
  logic                   wDrop;
  logic                   flush;
  logic                   flushBusy;
  logic [NPORT-1:0]       sValid;
  logic                   sReady;
  logic [NPORT*WIDTH-1:0] sPatt;
  logic [NPORT-1:0]       rValid;
  logic [NPORT-1:0]       rMatch;
  logic [NPORT-1:0]       rMulti;
  logic [NPORT*AW-1:0]    rAddr;
`ifdef CAM_MATCH_COUNT_EN
  logic [NPORT*CW-1:0]    rCount;
`endif

  int checks = 0;
  int errors = 0;

  mp_tcam_engine #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NPORT(NPORT), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n),
    .wEn(wEn), .wAddr(wAddr), .wPatt(wPatt), .wMask(wMask), .wValid(wValid), .wDrop(wDrop),
    .flush(flush), .flushBusy(flushBusy),
    .sValid(sValid), .sReady(sReady), .sPatt(sPatt),
    .rValid(rValid), .rMatch(rMatch), .rMulti(rMulti),
`ifdef CAM_MATCH_COUNT_EN
    .rCount(rCount),
`endif
    .rAddr(rAddr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] m,
                       input logic v);
    wEn = 1'b1; wAddr = a; wPatt = p; wMask = m; wValid = v;
    tick;
    wEn = 1'b0;
  endtask

  // Issue one search on both ports, then check the stage-3 result and its one-cycle width.
  task automatic search(input string tag, input logic [WIDTH-1:0] k0, input logic [WIDTH-1:0] k1,
                        input logic [1:0] em, input logic [1:0] emu,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input int c0, input int c1);
    sValid = 2'b11;
    sPatt  = {k1, k0};
    tick;
    sValid = 2'b00;
    wEn    = 1'b0;
    tick;
    tick;
    check({tag, "_rvalid"}, 64'(rValid), 64'(2'b11));
    check({tag, "_rmatch"}, 64'(rMatch), 64'(em));
    check({tag, "_rmulti"}, 64'(rMulti), 64'(emu));
    check({tag, "_raddr0"}, 64'(rAddr[AW-1:0]), 64'(a0));
    check({tag, "_raddr1"}, 64'(rAddr[2*AW-1:AW]), 64'(a1));
`ifdef CAM_MATCH_COUNT_EN
    check({tag, "_rcount0"}, 64'(rCount[CW-1:0]), 64'(c0));
    check({tag, "_rcount1"}, 64'(rCount[2*CW-1:CW]), 64'(c1));
`else
    if (c0 < 0 || c1 < 0) $display("note: negative count argument in %s", tag);
`endif
    tick;
    check({tag, "_rvalid_drop"}, 64'(rValid), 64'(2'b00));
  endtask

  initial begin
    rst_n = 1'b0; wEn = 1'b0; wAddr = '0; wPatt = '0; wMask = '0; wValid = 1'b0;
    flush = 1'b0; sValid = '0; sPatt = '0;

    // 1: reset state, then empty-table search
    #12;
    check("rst_rvalid", 64'(rValid), 64'(0));
    check("rst_rmatch", 64'(rMatch), 64'(0));
    check("rst_rmulti", 64'(rMulti), 64'(0));
    check("rst_raddr", 64'(rAddr), 64'(0));
    check("rst_busy", 64'(flushBusy), 64'(0));
    check("rst_wdrop", 64'(wDrop), 64'(0));
    tick;
    rst_n = 1'b1;
    tick;
    check("rst_sready", 64'(sReady), 64'(1));
    search("empty", 36'h0, 36'h0, 2'b00, 2'b00, 6'd0, 6'd0, 0, 0);

    // 2: exact entry 5 plus masked entry 9
    write(6'd5, 36'h123, 36'h0, 1'b1);
    write(6'd9, 36'h120, 36'hF, 1'b1);
    search("multi", 36'h123, 36'h12F, 2'b11, 2'b01, 6'd5, 6'd9, 2, 1);

    // 3: write-first on the same edge, then invalidate
    wEn = 1'b1; wAddr = 6'd3; wPatt = 36'hABC; wMask = 36'h0; wValid = 1'b1;
    search("same_edge", 36'hABC, 36'hABC, 2'b11, 2'b00, 6'd3, 6'd3, 1, 1);
    write(6'd3, 36'h0, 36'h0, 1'b0);
    search("invalidated", 36'hABC, 36'hABC, 2'b00, 2'b00, 6'd0, 6'd0, 0, 0);

    // 4: back-to-back streaming on both ports
    sValid = 2'b11;
    sPatt  = {36'h12F, 36'h123};
    for (int i = 0; i < 8; i++) begin
      tick;
      if (i == 3) sValid = 2'b00;
      check($sformatf("stream_rvalid_%0d", i), 64'(rValid), (i >= 2 && i <= 5) ? 64'(2'b11) : 64'(0));
      if (i >= 2 && i <= 5) begin
        check($sformatf("stream_raddr0_%0d", i), 64'(rAddr[AW-1:0]), 64'(5));
        check($sformatf("stream_raddr1_%0d", i), 64'(rAddr[2*AW-1:AW]), 64'(9));
      end
    end

    // 4b: invalidating entry 5 one edge after accept leaves the in-flight search untouched
    sValid = 2'b11;
    sPatt  = {36'h123, 36'h123};
    tick;
    sValid = 2'b00;
    wEn = 1'b1; wAddr = 6'd5; wValid = 1'b0;
    tick;
    wEn = 1'b0;
    tick;
    check("inflight_rmatch", 64'(rMatch), 64'(2'b11));
    check("inflight_raddr0", 64'(rAddr[AW-1:0]), 64'(5));
    tick;
    search("after_inval", 36'h123, 36'h123, 2'b11, 2'b00, 6'd9, 6'd9, 1, 1);

    // 5: flush with a same-edge write, a dropped write, a re-assert and blocked searches
    wEn = 1'b1; wAddr = 6'd20; wPatt = 36'h55; wMask = 36'h0; wValid = 1'b1;
    flush = 1'b1;
    tick;
    wEn = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("flush_busy_%0d", i), 64'(flushBusy), 64'(i < 8));
      check($sformatf("flush_sready_%0d", i), 64'(sReady), 64'(i >= 8));
      check($sformatf("flush_wdrop_%0d", i), 64'(wDrop), 64'(i == 5));
      check($sformatf("flush_rvalid_%0d", i), 64'(rValid), 64'(0));
      sValid = (i < 7) ? 2'b11 : 2'b00;
      sPatt  = {36'h77, 36'h55};
      wEn    = (i == 4);
      wAddr  = 6'd21; wPatt = 36'h77; wMask = 36'h0; wValid = 1'b1;
      flush  = (i == 6);
      tick;
    end
    wEn = 1'b0;
    flush = 1'b0;
    search("post_flush_a", 36'h55, 36'h77, 2'b00, 2'b00, 6'd0, 6'd0, 0, 0);
    search("post_flush_b", 36'h123, 36'h12F, 2'b00, 2'b00, 6'd0, 6'd0, 0, 0);

    // 6: reset in the middle of a flush kills the table and the pipeline
    write(6'd5, 36'h123, 36'h0, 1'b1);
    write(6'd40, 36'hF0, 36'h0, 1'b1);
    flush = 1'b1;
    sValid = 2'b11;
    sPatt = {36'h123, 36'h123};
    tick;
    flush = 1'b0;
    sValid = 2'b00;
    tick;
    tick;
    check("pre_rst_rvalid", 64'(rValid), 64'(2'b11));
    check("pre_rst_raddr0", 64'(rAddr[AW-1:0]), 64'(5));
    check("pre_rst_busy", 64'(flushBusy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(flushBusy), 64'(0));
    check("mid_rst_rvalid", 64'(rValid), 64'(0));
    check("mid_rst_rmatch", 64'(rMatch), 64'(0));
    check("mid_rst_sready", 64'(sReady), 64'(0));
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    check("post_rst_sready", 64'(sReady), 64'(1));
    check("post_rst_busy", 64'(flushBusy), 64'(0));
    search("post_rst", 36'h123, 36'hF0, 2'b00, 2'b00, 6'd0, 6'd0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
